data_sram_resp: RTL and testbench
=================================

DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 Parameter: DEPTH_LOG2, default 10, log2 of the number of 32-bit words (1024 words, 4 KiB).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 data_sram_en  input  1  request enable; a request exists only in cycles where this is 1.
REQ-005 data_sram_wen  input  4  byte write enables; [i] selects byte lane i (bits 8i+7:8i); 4'h0 with en=1 is a read.
REQ-006 data_sram_addr  input  32  byte address; bits [1:0] are ignored.
REQ-007 data_sram_wdata  input  32  write data, lane-aligned.
REQ-008 data_sram_rdata  output  32  read data, registered.
REQ-009 rdata_valid  output  1  1 for exactly the cycle in which data_sram_rdata carries the result of a read.
REQ-010 err  output  1  sticky out-of-range access flag.
REQ-011 rd_cnt  output  32  count of accepted reads.
REQ-012 wr_cnt  output  32  count of accepted writes.

Function
REQ-013 Word index SHALL be addr[DEPTH_LOG2+1:2]; an access is out of range when addr[31:DEPTH_LOG2+2] is nonzero.
REQ-014 An in-range write (en=1, wen!=0) SHALL update only the enabled byte lanes of the indexed word at the same clock edge; other lanes SHALL keep their values.
REQ-015 A read (en=1, wen=0) SHALL present the indexed word on data_sram_rdata with rdata_valid=1 in the next cycle: fixed latency of 1.
REQ-016 A request with en=1 and wen!=0 is a write only; it SHALL NOT assert rdata_valid.
REQ-017 Back-to-back reads SHALL each be answered in the following cycle; throughput is one request per cycle, with no stall path.
REQ-018 A read to a word written in the immediately preceding cycle SHALL return the newly written bytes.
REQ-019 When en=0, or after a write, data_sram_rdata SHALL hold its previous value and rdata_valid SHALL be 0.
REQ-020 An out-of-range write SHALL NOT modify the array; an out-of-range read SHALL return 32'h0 with rdata_valid=1.
REQ-021 Any out-of-range access SHALL set err to 1 the next cycle; err stays 1 until reset.
REQ-022 rd_cnt and wr_cnt SHALL increment by 1 per accepted read/write, including out-of-range ones, and SHALL wrap from 32'hFFFFFFFF to 0.
REQ-023 en=1 with addr bits [1:0] nonzero SHALL behave exactly as with those bits zero.

Reset
REQ-024 Reset SHALL asynchronously force data_sram_rdata=0, rdata_valid=0, err=0, rd_cnt=0, wr_cnt=0.
REQ-025 Array contents SHALL NOT be reset and SHALL be unaffected by reset.
REQ-026 A read issued in the cycle reset asserts SHALL be dropped, with no rdata_valid after reset.
REQ-027 Requests SHALL be honoured starting with the first clock edge after reset deasserts.

Structure
REQ-028 The lane count (4), the word width (32), the default DEPTH_LOG2 and the read-latency constant (1) SHALL live in the shared package/header used by the pipeline stages.
REQ-029 The byte-lane storage SHALL be one sub-module, sram_bank_bytewe: a synchronous-write, registered-read array with 4-bit lane enables; the counters, range check and err flag stay in data_sram_resp.

Verification
REQ-030 Write addr 0x10, wen 4'hF, wdata 0x12345678; read 0x10 next cycle -> the cycle after, rdata=0x12345678, rdata_valid=1, wr_cnt=1, rd_cnt=1.
REQ-031 Write 0x12345678 to 0x20, then write wen 4'b0101, wdata 0xAABBCCDD, then read 0x20 -> rdata=0x12BB56DD.
REQ-032 Reads to 0x0, 0x4, 0x8 on consecutive cycles after prior writes 1, 2, 3 -> rdata 1, 2, 3 on three consecutive cycles, each with rdata_valid=1.
REQ-033 Write 0xDEADBEEF to addr 0x00001000 (out of range at DEPTH_LOG2=10), then read 0x0 -> word 0 unchanged, err=1 and sticky; a read of 0x1000 returns 0x0.
REQ-034 Assert reset mid-stream with a read pending -> all outputs 0 immediately (asynchronous) and no rdata_valid; a read of a previously written word after release returns the old contents.
REQ-035 Preload wr_cnt to 32'hFFFFFFFF via force, then issue one write -> wr_cnt=0.

Source files
------------

// File: rtl/data_sram_resp_pkg.sv
// Shared constants for the data SRAM responder and its byte-lane storage bank.
package data_sram_resp_pkg;
  localparam int LANES          = 4;
  localparam int WORD_W         = 32;
  localparam int DEPTH_LOG2_DEF = 10;
  localparam int RD_LATENCY     = 1;
endpackage

// File: rtl/sram_bank_bytewe.sv
// Byte-lane SRAM bank: synchronous write with per-lane enables, registered read.
// Each lane is its own narrow array so every lane maps onto a plain block RAM.
module sram_bank_bytewe
  import data_sram_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic [LANES-1:0]      we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] q_reg;

      // No reset on array or read register; the output keeps its last read value.
      always_ff @(posedge clk) begin
        if (we[gi]) mem[addr] <= wdata[8*gi +: 8];
        if (re)     q_reg     <= mem[addr];
      end

      assign rdata[8*gi +: 8] = q_reg;
    end
  endgenerate
endmodule

// File: rtl/data_sram_resp.sv
// Single-cycle-latency data SRAM responder with range checking, sticky error
// flag and read/write counters; storage lives in sram_bank_bytewe.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_sram_en,
  input  logic [LANES-1:0]  data_sram_wen,
  input  logic [31:0]       data_sram_addr,
  input  logic [WORD_W-1:0] data_sram_wdata,
  output logic [WORD_W-1:0] data_sram_rdata,
  output logic              rdata_valid,
  output logic              err,
  output logic [31:0]       rd_cnt,
  output logic [31:0]       wr_cnt
);
  logic                  is_rd;
  logic                  is_wr;
  logic                  is_oor;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [LANES-1:0]      bank_we;
  logic                  bank_re;
  logic [WORD_W-1:0]     bank_rdata;
  logic                  unused_addr_lsb;

  logic                  rdata_valid_reg;
  logic                  rdata_zero_reg;
  logic                  err_reg;
  logic [31:0]           rd_cnt_reg;
  logic [31:0]           wr_cnt_reg;

  assign unused_addr_lsb = ^data_sram_addr[1:0];
  assign word_idx = data_sram_addr[DEPTH_LOG2+1:2];
  assign is_oor   = |data_sram_addr[31:DEPTH_LOG2+2];
  assign is_rd    = data_sram_en && (data_sram_wen == '0);
  assign is_wr    = data_sram_en && (data_sram_wen != '0);

  // Storage is frozen while reset is held so contents survive it untouched.
  assign bank_we = (is_wr && !is_oor && !reset) ? data_sram_wen : '0;
  assign bank_re = is_rd && !is_oor && !reset;

  sram_bank_bytewe #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_bank (
    .clk  (clk),
    .we   (bank_we),
    .re   (bank_re),
    .addr (word_idx),
    .wdata(data_sram_wdata),
    .rdata(bank_rdata)
  );

  // rdata_zero_reg masks the bank output after reset and for out-of-range reads;
  // the bank register itself holds between reads, giving the hold behaviour.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_valid_reg <= 1'b0;
      rdata_zero_reg  <= 1'b1;
      err_reg         <= 1'b0;
      rd_cnt_reg      <= '0;
      wr_cnt_reg      <= '0;
    end else begin
      rdata_valid_reg <= is_rd;
      if (is_rd)                 rdata_zero_reg <= is_oor;
      if (data_sram_en && is_oor) err_reg       <= 1'b1;
      if (is_rd)                 rd_cnt_reg     <= rd_cnt_reg + 32'd1;
      if (is_wr)                 wr_cnt_reg     <= wr_cnt_reg + 32'd1;
    end
  end

  assign data_sram_rdata = rdata_zero_reg ? '0 : bank_rdata;
  assign rdata_valid     = rdata_valid_reg;
  assign err             = err_reg;
  assign rd_cnt          = rd_cnt_reg;
  assign wr_cnt          = wr_cnt_reg;
endmodule

// File: tb/tb_data_sram_resp.sv
// Scoreboard bench for data_sram_resp: reads push expected words, a negedge
// monitor pops and compares them, scenario tasks check counters and flags.
module tb_data_sram_resp;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        data_sram_en = 1'b0;
  logic [3:0]  data_sram_wen = 4'h0;
  logic [31:0] data_sram_addr = 32'h0;
  logic [31:0] data_sram_wdata = 32'h0;
  logic [31:0] data_sram_rdata;
  logic        rdata_valid;
  logic        err;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] sb_q [$];
  logic [31:0] model_mem [0:1023];
  logic [31:0] exp_rd = 0;
  logic [31:0] exp_wr = 0;
  logic        exp_err = 1'b0;
  logic        exp_valid = 1'b0;
  logic [31:0] hold_exp = 32'h0;

  data_sram_resp dut (
    .clk            (clk),
    .reset          (reset),
    .data_sram_en   (data_sram_en),
    .data_sram_wen  (data_sram_wen),
    .data_sram_addr (data_sram_addr),
    .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata),
    .rdata_valid    (rdata_valid),
    .err            (err),
    .rd_cnt         (rd_cnt),
    .wr_cnt         (wr_cnt)
  );

  always #5 clk = ~clk;

  // A read seen at an edge outside reset must be answered one cycle later.
  always @(posedge clk or posedge reset) begin
    if (reset) exp_valid <= 1'b0;
    else       exp_valid <= data_sram_en && (data_sram_wen == 4'h0);
  end

  always @(negedge clk) begin
    n_checks++;
    if (rdata_valid !== exp_valid) begin
      n_fail++;
      $display("FAIL rdata_valid: got %b, expected %b at %0t", rdata_valid, exp_valid, $time);
    end
    if (rdata_valid === 1'b1) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_read: rdata %h with empty scoreboard at %0t", data_sram_rdata, $time);
      end else begin
        hold_exp = sb_q.pop_front();
        if (data_sram_rdata !== hold_exp) begin
          n_fail++;
          $display("FAIL read_data: got %h, expected %h at %0t", data_sram_rdata, hold_exp, $time);
        end else
          $display("read  ok: rdata %h at %0t", data_sram_rdata, $time);
      end
    end else begin
      n_checks++;
      if (data_sram_rdata !== hold_exp) begin
        n_fail++;
        $display("FAIL rdata_hold: got %h, expected %h at %0t", data_sram_rdata, hold_exp, $time);
      end
    end
  end

  function automatic logic in_range(input logic [31:0] a);
    return a[31:12] == 20'h0;
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [3:0] wen, input logic [31:0] d);
    logic [31:0] w;
    @(posedge clk); #1;
    data_sram_en = 1'b1; data_sram_wen = wen; data_sram_addr = a; data_sram_wdata = d;
    exp_wr = exp_wr + 1;
    if (in_range(a)) begin
      w = model_mem[a[11:2]];
      for (int i = 0; i < 4; i++) if (wen[i]) w[8*i +: 8] = d[8*i +: 8];
      model_mem[a[11:2]] = w;
    end else exp_err = 1'b1;
    $display("write addr %h wen %h data %h", a, wen, d);
  endtask

  task automatic do_read(input logic [31:0] a);
    @(posedge clk); #1;
    data_sram_en = 1'b1; data_sram_wen = 4'h0; data_sram_addr = a; data_sram_wdata = $urandom;
    exp_rd = exp_rd + 1;
    if (in_range(a)) sb_q.push_back(model_mem[a[11:2]]);
    else begin sb_q.push_back(32'h0); exp_err = 1'b1; end
    $display("read  addr %h issued", a);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    data_sram_en = 1'b0; data_sram_wen = $urandom; data_sram_addr = $urandom;
    @(negedge clk);
  endtask

  task automatic check_status(input string tag);
    n_checks++;
    if (rd_cnt !== exp_rd) begin n_fail++; $display("FAIL %s rd_cnt: got %h, expected %h", tag, rd_cnt, exp_rd); end
    n_checks++;
    if (wr_cnt !== exp_wr) begin n_fail++; $display("FAIL %s wr_cnt: got %h, expected %h", tag, wr_cnt, exp_wr); end
    n_checks++;
    if (err !== exp_err) begin n_fail++; $display("FAIL %s err: got %b, expected %b", tag, err, exp_err); end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    check_status("reset");
    n_checks++;
    if (data_sram_rdata !== 32'h0 || rdata_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %h/%b, expected 0/0", data_sram_rdata, rdata_valid);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    do_write(32'h10, 4'hF, 32'h12345678);
    do_read(32'h10);
    idle();
    check_status("basic");
  endtask

  task automatic test_byte_lanes();
    do_write(32'h20, 4'hF, 32'h12345678);
    do_write(32'h20, 4'b0101, 32'hAABBCCDD);
    do_read(32'h20);
    idle();
    do_read(32'h23);  // low address bits are ignored
    do_write(32'h24, 4'b1010, 32'h11223344);
    idle();
    check_status("byte_lanes");
  endtask

  task automatic test_back_to_back();
    do_write(32'h0, 4'hF, 32'd1);
    do_write(32'h4, 4'hF, 32'd2);
    do_write(32'h8, 4'hF, 32'd3);
    do_read(32'h0);
    do_read(32'h4);
    do_read(32'h8);
    do_read(32'h5);
    idle();
    repeat (3) @(negedge clk);
    check_status("back_to_back");
  endtask

  task automatic test_out_of_range();
    do_write(32'h00001000, 4'hF, 32'hDEADBEEF);
    do_read(32'h0);
    idle();
    check_status("oor_write");
    do_read(32'h00001000);
    do_read(32'h8);
    idle();
    repeat (3) @(negedge clk);
    check_status("oor_sticky");
  endtask

  task automatic test_reset_midstream();
    do_read(32'h10);
    #2 reset = 1'b1;
    #1;
    sb_q.delete();
    hold_exp = 32'h0;
    exp_rd = 0; exp_wr = 0; exp_err = 1'b0;
    check_status("async_reset");
    n_checks++;
    if (data_sram_rdata !== 32'h0 || rdata_valid !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_outputs: got %h/%b, expected 0/0", data_sram_rdata, rdata_valid);
    end
    @(posedge clk); #1;
    data_sram_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_status("after_reset");
    do_read(32'h10);
    do_read(32'h20);
    idle();
    check_status("post_reset_read");
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.wr_cnt_reg = 32'hFFFFFFFF;
    #1 release dut.wr_cnt_reg;
    exp_wr = 32'hFFFFFFFF;
    check_status("wrap_preload");
    do_write(32'h40, 4'hF, 32'hCAFEF00D);
    idle();
    check_status("wrap");
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) model_mem[i] = 32'h0;
    test_reset();
    test_basic();
    test_byte_lanes();
    test_back_to_back();
    test_out_of_range();
    test_reset_midstream();
    test_wrap();
    begin
      int budget;
      budget = 20;
      while (sb_q.size() != 0 && budget > 0) begin @(negedge clk); budget--; end
      n_checks++;
      if (sb_q.size() != 0) begin
        n_fail++; $display("FAIL drain: %0d reads unanswered, expected 0", sb_q.size());
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
